// File: rtl/hv_bist_pkg.sv
// Purpose     : shared types and constants for the HV self-test sequencer.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (3-bit FSM encoding), analog BIST item bit indices,
// default timing parameters and the derived settle/timeout cycle counts.
package hv_bist_pkg;

  localparam int unsigned CLK_M_DEF         = 48;   // clock cycles per microsecond
  localparam int unsigned BIST_ITEM_NUM_DEF = 6;
  localparam int unsigned SETTLE_US_DEF     = 10;
  localparam int unsigned TMO_US_DEF        = 500;
  localparam int unsigned RETRY_MAX         = 1;

  localparam int unsigned SETTLE_CYC = SETTLE_US_DEF * CLK_M_DEF;
  localparam int unsigned TMO_CYC    = TMO_US_DEF * CLK_M_DEF;

  // Bit positions inside i_abist_status / o_fail_vec.
  localparam int unsigned IDX_OV     = 0;
  localparam int unsigned IDX_OT     = 1;
  localparam int unsigned IDX_OPSCOD = 2;
  localparam int unsigned IDX_OC     = 3;
  localparam int unsigned IDX_SC     = 4;
  localparam int unsigned IDX_ADC    = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_ABIST    = 3'd3,
    ST_CHECK    = 3'd4,
    ST_LBIST    = 3'd5,
    ST_RETRY    = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

endpackage

// File: rtl/hv_bist_seq_ctrl_us_cnt.sv
// Purpose     : loadable saturating down-counter with a zero flag.
// Latency     : load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; en simply pauses the count.
// Ports: clk, rst_n (async active-low), load/load_val, en (decrement), zero (count == 0).
module hv_bist_us_cnt #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hv_bist_seq_ctrl.sv
// Purpose     : HV self-test sequencer: supply qualify, settle, analog BIST, logic BIST, summary.
// Latency     : SETTLE lasts SETTLE_US*CLK_M cycles; timeout fires TMO_US*CLK_M cycles after SETTLE exit.
// Backpressure: requests are only accepted in IDLE/DONE; a request while busy is dropped.
// Ports: i_clk/i_rst_n; i_bist_req, i_vcc_rdy in; o_bist_en, i_abist_fin, i_abist_status
// (analog engine); o_lbist_start, i_lbist_done, i_lbist_pass (logic BIST); o_busy, o_done,
// o_pass, o_fail_vec, o_lbist_fail, o_tmo, o_abort, o_state (results/debug).
// Build option: HV_BIST_RETRY_EN adds the RETRY state and retry counter.
module hv_bist_seq_ctrl
  import hv_bist_pkg::*;
#(
  parameter int unsigned CLK_M         = CLK_M_DEF,
  parameter int unsigned BIST_ITEM_NUM = BIST_ITEM_NUM_DEF,
  parameter int unsigned SETTLE_US     = SETTLE_US_DEF,
  parameter int unsigned TMO_US        = TMO_US_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bist_req,
  input  logic                     i_vcc_rdy,
  output logic                     o_bist_en,
  input  logic                     i_abist_fin,
  input  logic [BIST_ITEM_NUM-1:0] i_abist_status,
  output logic                     o_lbist_start,
  input  logic                     i_lbist_done,
  input  logic                     i_lbist_pass,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [BIST_ITEM_NUM-1:0] o_fail_vec,
  output logic                     o_lbist_fail,
  output logic                     o_tmo,
  output logic                     o_abort,
  output logic [2:0]               o_state
);

  localparam int unsigned SET_CYC = SETTLE_US * CLK_M;
  localparam int unsigned TMO_LIM = TMO_US * CLK_M;
  localparam int unsigned SW      = $clog2(SET_CYC + 1);
  localparam int unsigned TW      = $clog2(TMO_LIM + 1);
  // Counters load N-1 so that zero is seen in the Nth cycle and the move lands exactly N edges later.
  localparam logic [SW-1:0] SET_LD = SW'(SET_CYC - 1);
  localparam logic [TW-1:0] TMO_LD = TW'(TMO_LIM - 1);

  state_t state, state_nxt;

  logic [BIST_ITEM_NUM-1:0] fail_vec_nxt;
  logic lbist_fail_nxt, tmo_nxt, abort_nxt, pass_nxt, bist_en_nxt;
  logic settle_load, settle_zero;
  logic tmo_load, tmo_en, tmo_zero;
  logic vcc_lost, tmo_hit;

`ifdef HV_BIST_RETRY_EN
  localparam int unsigned RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_cnt, retry_cnt_nxt;
  logic          rty_ph, rty_ph_nxt;   // second of the two RETRY cycles
`endif

  assign vcc_lost = !i_vcc_rdy &&
                    (state inside {ST_SETTLE, ST_ABIST, ST_CHECK, ST_LBIST, ST_RETRY});
  assign tmo_hit  = tmo_zero && (state inside {ST_ABIST, ST_CHECK, ST_LBIST, ST_RETRY});

  // The timeout is global: it starts at the first SETTLE exit and keeps running
  // through any re-settle after a retry, so it is only reloaded on request acceptance.
`ifdef HV_BIST_RETRY_EN
  assign tmo_en = (state inside {ST_ABIST, ST_CHECK, ST_LBIST, ST_RETRY}) ||
                  ((state == ST_SETTLE) && (retry_cnt != '0));
`else
  assign tmo_en = state inside {ST_ABIST, ST_CHECK, ST_LBIST};
`endif

  hv_bist_us_cnt #(.W(SW)) u_settle_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (settle_load),
    .load_val (SET_LD),
    .en       (state == ST_SETTLE),
    .zero     (settle_zero)
  );

  hv_bist_us_cnt #(.W(TW)) u_tmo_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmo_load),
    .load_val (TMO_LD),
    .en       (tmo_en),
    .zero     (tmo_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fail_vec_nxt   = o_fail_vec;
    lbist_fail_nxt = o_lbist_fail;
    tmo_nxt        = o_tmo;
    abort_nxt      = o_abort;
    pass_nxt       = o_pass;
    settle_load    = 1'b0;
    tmo_load       = 1'b0;
    bist_en_nxt    = 1'b0;
`ifdef HV_BIST_RETRY_EN
    retry_cnt_nxt  = retry_cnt;
    rty_ph_nxt     = rty_ph;
`endif

    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_bist_req) begin
          state_nxt      = ST_WAIT_RDY;
          fail_vec_nxt   = '0;
          lbist_fail_nxt = 1'b0;
          tmo_nxt        = 1'b0;
          abort_nxt      = 1'b0;
          pass_nxt       = 1'b0;
          tmo_load       = 1'b1;
`ifdef HV_BIST_RETRY_EN
          retry_cnt_nxt  = '0;
`endif
        end
      end
      ST_WAIT_RDY: begin
        if (i_vcc_rdy) begin
          state_nxt   = ST_SETTLE;
          settle_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (vcc_lost) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (settle_zero) begin
          state_nxt = ST_ABIST;
        end
      end
      ST_ABIST: begin
        if (vcc_lost) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (tmo_hit) begin
          state_nxt    = ST_DONE;
          tmo_nxt      = 1'b1;
          fail_vec_nxt = i_abist_status;
        end else if (i_abist_fin) begin
          state_nxt    = ST_CHECK;
          fail_vec_nxt = i_abist_status;
        end
      end
      ST_CHECK: begin
        if (vcc_lost) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          tmo_nxt   = 1'b1;
        end else if (o_fail_vec == '0) begin
          state_nxt = ST_LBIST;
`ifdef HV_BIST_RETRY_EN
        end else if (retry_cnt < RW'(RETRY_MAX)) begin
          state_nxt  = ST_RETRY;
          rty_ph_nxt = 1'b0;
`endif
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_LBIST: begin
        // A valid LBIST result beats a same-cycle timeout; a supply loss beats both.
        if (vcc_lost) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (i_lbist_done) begin
          state_nxt      = ST_DONE;
          lbist_fail_nxt = !i_lbist_pass;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          tmo_nxt   = 1'b1;
        end
      end
`ifdef HV_BIST_RETRY_EN
      ST_RETRY: begin
        if (vcc_lost) begin
          state_nxt = ST_DONE;
          abort_nxt = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          tmo_nxt   = 1'b1;
        end else if (!rty_ph) begin
          rty_ph_nxt = 1'b1;
        end else begin
          state_nxt     = ST_SETTLE;
          settle_load   = 1'b1;
          retry_cnt_nxt = retry_cnt + RW'(1);
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
      pass_nxt = (fail_vec_nxt == '0) && !lbist_fail_nxt && !tmo_nxt && !abort_nxt;
    end

    bist_en_nxt = state_nxt inside {ST_ABIST, ST_CHECK, ST_LBIST};
`ifdef HV_BIST_RETRY_EN
    // On a re-settle the supply is already good, so the engine is re-enabled
    // right after the two-cycle low pulse that restarts it.
    if ((state_nxt == ST_SETTLE) && (retry_cnt_nxt != '0)) begin
      bist_en_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fail_vec    <= '0;
      o_lbist_fail  <= 1'b0;
      o_tmo         <= 1'b0;
      o_abort       <= 1'b0;
      o_pass        <= 1'b0;
      o_bist_en     <= 1'b0;
      o_lbist_start <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
`ifdef HV_BIST_RETRY_EN
      retry_cnt     <= '0;
      rty_ph        <= 1'b0;
`endif
    end else begin
      o_fail_vec    <= fail_vec_nxt;
      o_lbist_fail  <= lbist_fail_nxt;
      o_tmo         <= tmo_nxt;
      o_abort       <= abort_nxt;
      o_pass        <= pass_nxt;
      o_bist_en     <= bist_en_nxt;
      o_lbist_start <= (state_nxt == ST_LBIST) && (state != ST_LBIST);
      o_busy        <= !(state_nxt inside {ST_IDLE, ST_DONE});
      o_done        <= (state_nxt == ST_DONE);
`ifdef HV_BIST_RETRY_EN
      retry_cnt     <= retry_cnt_nxt;
      rty_ph        <= rty_ph_nxt;
`endif
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_hv_bist_seq_ctrl.sv
// Purpose     : directed self-checking bench for hv_bist_seq_ctrl.
// Latency     : n/a.
// Backpressure: n/a.
// Scenarios: reset, nominal pass, analog fail (or retry when HV_BIST_RETRY_EN is
// defined), global timeout, abort with ignored request, reset during ABIST.
module tb_hv_bist_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, bist_req, vcc_rdy, abist_fin, lbist_done, lbist_pass;
  logic [5:0] abist_status;
  logic       bist_en, lbist_start, busy, done, pass, lbist_fail, tmo, abort_o;
  logic [5:0] fail_vec;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hv_bist_seq_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bist_req     (bist_req),
    .i_vcc_rdy      (vcc_rdy),
    .o_bist_en      (bist_en),
    .i_abist_fin    (abist_fin),
    .i_abist_status (abist_status),
    .o_lbist_start  (lbist_start),
    .i_lbist_done   (lbist_done),
    .i_lbist_pass   (lbist_pass),
    .o_busy         (busy),
    .o_done         (done),
    .o_pass         (pass),
    .o_fail_vec     (fail_vec),
    .o_lbist_fail   (lbist_fail),
    .o_tmo          (tmo),
    .o_abort        (abort_o),
    .o_state        (state)
  );

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    bist_req = 1'b1;
    tick(1);
    bist_req = 1'b0;
  endtask

  // From IDLE/DONE with vcc_rdy high: request, enter SETTLE, then count edges
  // until o_bist_en rises (bounded).
  task automatic start_to_abist(output int k);
    pulse_req();
    tick(1);
    k = 0;
    while (bist_en !== 1'b1 && k < 600) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bist_req = 1'b0; vcc_rdy = 1'b1; abist_fin = 1'b0;
    lbist_done = 1'b0; lbist_pass = 1'b0; abist_status = '0;
    #12;
    n_chk++;
    if ({bist_en, lbist_start, busy, done, pass, lbist_fail, tmo, abort_o} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000000",
                         {bist_en, lbist_start, busy, done, pass, lbist_fail, tmo, abort_o});
    end
    n_chk++;
    if (fail_vec !== 6'h00) begin n_fail++; $display("FAIL reset_fail_vec: got %h expected 00", fail_vec); end
    n_chk++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    n_chk++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: state %0d busy %b expected 0/0", state, busy);
    end
  endtask

  task automatic test_nominal();
    int k;
    int starts;
    pulse_req();
    n_chk++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL nom_accept: state %0d busy %b expected 1/1", state, busy);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd2 || bist_en !== 1'b0) begin
      n_fail++; $display("FAIL nom_settle: state %0d bist_en %b expected 2/0", state, bist_en);
    end
    k = 0;
    while (bist_en !== 1'b1 && k < 600) begin
      tick(1);
      k++;
    end
    n_chk++;
    if (k != 480) begin n_fail++; $display("FAIL nom_settle_len: got %0d expected 480", k); end
    n_chk++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL nom_abist: state %0d expected 3", state); end
    tick(3000);
    abist_status = 6'h00;
    abist_fin    = 1'b1;
    tick(1);
    abist_fin = 1'b0;
    n_chk++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL nom_check: state %0d expected 4", state); end
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (lbist_start === 1'b1) starts++;
    end
    lbist_done = 1'b1;
    lbist_pass = 1'b1;
    tick(1);
    lbist_done = 1'b0;
    n_chk++;
    if (starts != 1) begin n_fail++; $display("FAIL nom_lbist_start: got %0d pulses expected 1", starts); end
    n_chk++;
    if ({state, done, pass, busy, bist_en, lbist_fail} !== {3'd7, 5'b11000}) begin
      n_fail++; $display("FAIL nom_done: state %0d done %b pass %b busy %b en %b lfail %b expected 7 1 1 0 0 0",
                         state, done, pass, busy, bist_en, lbist_fail);
    end
  endtask

`ifndef HV_BIST_RETRY_EN
  task automatic test_analog_fail();
    int k;
    int starts;
    start_to_abist(k);
    n_chk++;
    if (done !== 1'b0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL af_clear: done %b pass %b expected 0/0", done, pass);
    end
    abist_status = 6'b000100;
    abist_fin    = 1'b1;
    starts       = 0;
    tick(1);
    abist_fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (lbist_start === 1'b1) starts++;
    end
    abist_status = '0;
    n_chk++;
    if (state !== 3'd7 || done !== 1'b1 || pass !== 1'b0) begin
      n_fail++; $display("FAIL af_done: state %0d done %b pass %b expected 7 1 0", state, done, pass);
    end
    n_chk++;
    if (fail_vec !== 6'h04) begin n_fail++; $display("FAIL af_fail_vec: got %h expected 04", fail_vec); end
    n_chk++;
    if (starts != 0) begin n_fail++; $display("FAIL af_no_lbist: got %0d pulses expected 0", starts); end
  endtask
`else
  task automatic test_retry();
    int k;
    int lo;
    start_to_abist(k);
    abist_status = 6'h01;
    abist_fin    = 1'b1;
    tick(1);
    abist_fin    = 1'b0;
    abist_status = 6'h00;
    n_chk++;
    if (fail_vec !== 6'h01) begin n_fail++; $display("FAIL rt_first_vec: got %h expected 01", fail_vec); end
    tick(1);
    n_chk++;
    if (state !== 3'd6) begin n_fail++; $display("FAIL rt_retry: state %0d expected 6", state); end
    lo = 0;
    while (bist_en === 1'b0 && lo < 10) begin
      lo++;
      tick(1);
    end
    n_chk++;
    if (lo != 2) begin n_fail++; $display("FAIL rt_en_low: got %0d cycles expected 2", lo); end
    n_chk++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL rt_resettle: state %0d expected 2", state); end
    k = 0;
    while (state !== 3'd3 && k < 600) begin
      tick(1);
      k++;
    end
    abist_fin = 1'b1;
    tick(1);
    abist_fin = 1'b0;
    tick(1);
    lbist_done = 1'b1;
    lbist_pass = 1'b1;
    tick(1);
    lbist_done = 1'b0;
    n_chk++;
    if (state !== 3'd7 || pass !== 1'b1 || fail_vec !== 6'h00) begin
      n_fail++; $display("FAIL rt_final: state %0d pass %b vec %h expected 7 1 00", state, pass, fail_vec);
    end
  endtask
`endif

  task automatic test_timeout();
    int k;
    start_to_abist(k);
    abist_status = 6'h2A;
    k = 0;
    while (tmo !== 1'b1 && k < 25000) begin
      tick(1);
      k++;
    end
    abist_status = 6'h00;
    n_chk++;
    if (k != 24000) begin n_fail++; $display("FAIL tmo_len: got %0d expected 24000", k); end
    n_chk++;
    if ({state, done, pass, bist_en} !== {3'd7, 3'b100}) begin
      n_fail++; $display("FAIL tmo_done: state %0d done %b pass %b en %b expected 7 1 0 0",
                         state, done, pass, bist_en);
    end
    n_chk++;
    if (fail_vec !== 6'h2A) begin n_fail++; $display("FAIL tmo_live_vec: got %h expected 2a", fail_vec); end
  endtask

  task automatic test_abort();
    int k;
    start_to_abist(k);
    n_chk++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL ab_tmo_cleared: got %b expected 0", tmo); end
    abist_status = 6'h00;
    abist_fin    = 1'b1;
    tick(1);
    abist_fin = 1'b0;
    tick(1);
    n_chk++;
    if (state !== 3'd5 || lbist_start !== 1'b1) begin
      n_fail++; $display("FAIL ab_lbist: state %0d start %b expected 5 1", state, lbist_start);
    end
    pulse_req();
    n_chk++;
    if (state !== 3'd5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ab_req_ignored: state %0d busy %b expected 5 1", state, busy);
    end
    vcc_rdy = 1'b0;
    tick(1);
    n_chk++;
    if ({state, abort_o, done, pass, busy, bist_en} !== {3'd7, 5'b11000}) begin
      n_fail++; $display("FAIL ab_done: state %0d abort %b done %b pass %b busy %b en %b expected 7 1 1 0 0 0",
                         state, abort_o, done, pass, busy, bist_en);
    end
    vcc_rdy = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_mid_abist();
    int k;
    start_to_abist(k);
    tick(10);
    n_chk++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL rm_in_abist: state %0d expected 3", state); end
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({bist_en, lbist_start, busy, done, pass, lbist_fail, tmo, abort_o, fail_vec, state} !== 17'h0) begin
      n_fail++; $display("FAIL rm_async_clear: en %b busy %b done %b abort %b vec %h state %0d expected all 0",
                         bist_en, busy, done, abort_o, fail_vec, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    start_to_abist(k);
    n_chk++;
    if (k != 480) begin n_fail++; $display("FAIL rm_settle_len: got %0d expected 480", k); end
    abist_status = 6'h00;
    abist_fin    = 1'b1;
    tick(1);
    abist_fin = 1'b0;
    tick(1);
    lbist_done = 1'b1;
    lbist_pass = 1'b1;
    tick(1);
    lbist_done = 1'b0;
    n_chk++;
    if ({state, done, pass, tmo, abort_o, fail_vec} !== {3'd7, 4'b1100, 6'h00}) begin
      n_fail++; $display("FAIL rm_clean_run: state %0d done %b pass %b tmo %b abort %b vec %h expected 7 1 1 0 0 00",
                         state, done, pass, tmo, abort_o, fail_vec);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
`ifndef HV_BIST_RETRY_EN
    test_analog_fail();
`else
    test_retry();
`endif
    test_timeout();
    test_abort();
    test_reset_mid_abist();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
